max_idx_arbiter: RTL and testbench
==================================

# max_idx_arbiter

Round-robin arbiter that shares one 10-input signed argmax engine (`max_idx10`) among `NREQ` classifier requesters. Each requester offers a 10-element score vector over a valid/ready handshake. The arbiter grants one requester, latches its vector, sequences the engine through `start`/`done`, and returns the winning index on a single tagged response channel. One transaction is in flight at a time.

## Interface
- `WIDTH`, default 8: signed score width, passed to the engine.
- `NREQ`, default 4: number of requesters, 1..16.
- `ID_W`, default `$clog2(NREQ)`, minimum 1: width of the requester tag.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  reset; synchronous, active-high.
- `req_valid`  in  `[NREQ]`  requester has a vector.
- `req_data`  in  `[NREQ][10]` x `WIDTH` signed  score vectors.
- `req_ready`  out  `[NREQ]`  one-hot grant/accept.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_idx`  out  4  argmax index, 0..9.
- `resp_id`  out  `ID_W`  requester that owns `resp_idx`.
- `busy`  out  1  high in every state other than IDLE.

## Operation
- FSM states:
  - IDLE: accepts a request; goes to ISSUE.
  - ISSUE: drives `start`=1 for exactly this cycle; goes to WAIT.
  - WAIT: on engine `done`=1, latches engine `idx` into `resp_idx`; goes to RESP.
  - RESP: on `resp_ready`=1, goes to IDLE.
- Arbitration (combinational, IDLE only):
  - Winner w is the first asserted `req_valid` scanning from `(last+1) mod NREQ` upward with wrap.
  - `req_ready[w]`=1; all other `req_ready` bits are 0.
  - `req_ready` is 0 in every state other than IDLE, and is 0 while `reset` is high.
- On accept (`req_valid[w]` & `req_ready[w]`):
  - Latch `req_data[w]` into the internal vector register.
  - `id` ← w, `last` ← w.
- The engine's `inputs` are driven from the latched vector only, never from `req_data` directly.
- Engine `done` is a level signal: set one cycle after its final state, cleared one cycle after `start` is sampled. It is therefore 0 on the first WAIT cycle and no guard is needed.
- A requester dropping `req_valid` before it is granted incurs no obligation. Arbitration re-evaluates every IDLE cycle.
- A requester that re-requests while its own result is pending waits until IDLE.
- Reset values: state IDLE, `last`=NREQ-1 (requester 0 wins first), `resp_valid`=0, `resp_idx`=0, `resp_id`=0, `busy`=0, engine in reset.
- Reset mid-transaction: abandon the transaction; no response is ever produced for it.

## Timing
- Accept at the edge ending cycle t.
- t+1 ISSUE (`start`=1).
- t+2..t+4: engine internal stages.
- t+5: engine `done`=1 with valid `idx`; arbiter captures.
- t+6: `resp_valid`=1.
- Minimum request-to-request period is 7 cycles with `resp_ready` held high. The next accept can occur at t+7.
- Under backpressure, `resp_valid`, `resp_idx`, and `resp_id` hold stable until the handshake completes. `resp_valid` drops the cycle after `resp_ready` is sampled high.
- Response arithmetic: none. The index is passed through unchanged (4 bits, values 0..9).

## Structure
- Package `gusn_argmax_pkg`:
  - `N_CLASSES`=10.
  - `IDX_W`=4.
  - `arb_state_t` enum {IDLE, ISSUE, WAIT, RESP}, 2 bits.
- Sub-module `rr_pick`: combinational round-robin picker.
  - Inputs: `req[NREQ]`, `last`.
  - Outputs: one-hot `grant`, encoded `grant_id`, `any`.
- `max_idx10` is instantiated once inside the arbiter, with `WIDTH` passed through and `reset` shared.

## Test plan
- Single request: req0 = {3,-5,7,1,0,6,2,-8,5,4}, `resp_ready`=1. Required: `resp_valid` at t+6, `resp_idx`=2, `resp_id`=0, one-cycle pulse.
- Negative extreme: vector all -128 except element 9 = -1. Required: `resp_idx`=9.
- Same vector with element 0 = 127. Required: `resp_idx`=0.
- All 4 requesters valid from reset, `resp_ready`=1. Required: served in order 0,1,2,3, accepts spaced 7 cycles apart, each `resp_id` matching its distinct planted max.
- Fairness: req1 and req3 held valid after req1 was last served. Required: order 3, then 1, then 3.
- Backpressure: `resp_ready`=0 for 5 cycles in RESP. Required: outputs stable, `req_ready` all 0, `busy`=1; release completes the handshake and returns to IDLE next cycle.
- Reset asserted for 1 cycle during WAIT. Required: no `resp_valid`, `busy`=0 after reset, and a following req2 is served with `resp_id`=2 and correct idx.

Source files
------------

// File: rtl/max_idx_arbiter_pkg.sv
// Shared constants and state encodings for the argmax arbiter and its engine.
// The package name is shared with the rest of the classifier slice.
package gusn_argmax_pkg;

    localparam int N_CLASSES = 10;
    localparam int IDX_W     = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        ENG_IDLE = 2'd0,
        ENG_ST1  = 2'd1,
        ENG_ST2  = 2'd2,
        ENG_ST3  = 2'd3
    } eng_state_t;

endpackage

// File: rtl/max_idx10.sv
// Three-stage signed argmax over 10 scores. 'done' is a level: set after the
// final stage, cleared as soon as a new 'start' is sampled.
module max_idx10
    import gusn_argmax_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] inputs [N_CLASSES],
    output logic                    done,
    output logic [IDX_W-1:0]        idx
);

    typedef struct packed {
        logic signed [WIDTH-1:0] val;
        logic [IDX_W-1:0]        pos;
    } cand_t;

    // 'a' always carries the lower index, so ties resolve to the lower index.
    function automatic cand_t pick(input cand_t a, input cand_t b);
        return ($signed(b.val) > $signed(a.val)) ? b : a;
    endfunction

    eng_state_t       state_q, state_d;
    cand_t            in_c [N_CLASSES];
    cand_t            s1_q [5];
    cand_t            s1_d [5];
    cand_t            s2_q [3];
    cand_t            s2_d [3];
    cand_t            fin;
    logic             done_q, done_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ENG_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ENG_ST1;
        end else begin
            case (state_q)
                ENG_ST1: state_d = ENG_ST2;
                ENG_ST2: state_d = ENG_ST3;
                ENG_ST3: state_d = ENG_IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CLASSES; i++) begin
            in_c[i].val = inputs[i];
            in_c[i].pos = IDX_W'(i);
        end
    end

    always_comb begin
        s1_d   = s1_q;
        s2_d   = s2_q;
        done_d = done_q;
        idx_d  = idx_q;
        fin    = pick(pick(s2_q[0], s2_q[1]), s2_q[2]);
        if (start) begin
            done_d = 1'b0;
        end
        case (state_q)
            ENG_ST1: begin
                for (int unsigned p = 0; p < 5; p++) begin
                    s1_d[p] = pick(in_c[2*p], in_c[2*p+1]);
                end
            end
            ENG_ST2: begin
                s2_d[0] = pick(s1_q[0], s1_q[1]);
                s2_d[1] = pick(s1_q[2], s1_q[3]);
                s2_d[2] = s1_q[4];
            end
            ENG_ST3: begin
                if (!start) begin
                    idx_d  = fin.pos;
                    done_d = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q   <= '{default: '0};
            s2_q   <= '{default: '0};
            done_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            s1_q   <= s1_d;
            s2_q   <= s2_d;
            done_q <= done_d;
            idx_q  <= idx_d;
        end
    end

    always_comb begin
        done = done_q;
        idx  = idx_q;
    end

endmodule

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first asserted request after 'last',
// scanning upward with wrap-around.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int ID_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [ID_W-1:0] last,
    output logic [NREQ-1:0] grant,
    output logic [ID_W-1:0] grant_id,
    output logic            any
);

    logic [ID_W-1:0] cand;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        any      = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = ID_W'((32'(last) + k) % NREQ);
            if (!any && req[cand]) begin
                any      = 1'b1;
                grant_id = cand;
            end
        end
        if (any) begin
            grant[grant_id] = 1'b1;
        end
    end

endmodule

// File: rtl/max_idx_arbiter.sv
// Round-robin arbiter sharing one argmax engine among NREQ requesters;
// one transaction in flight, result returned on a tagged response channel.
module max_idx_arbiter
    import gusn_argmax_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int ID_W  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NREQ-1:0]         req_valid,
    input  logic signed [WIDTH-1:0] req_data [NREQ][N_CLASSES],
    output logic [NREQ-1:0]         req_ready,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic [IDX_W-1:0]        resp_idx,
    output logic [ID_W-1:0]         resp_id,
    output logic                    busy
);

    arb_state_t              state_q, state_d;
    logic [NREQ-1:0]         grant;
    logic [ID_W-1:0]         grant_id;
    logic                    any;
    logic                    accept;
    logic [ID_W-1:0]         last_q, last_d;
    logic [ID_W-1:0]         id_q, id_d;
    logic [IDX_W-1:0]        resp_idx_q, resp_idx_d;
    logic signed [WIDTH-1:0] vec_q [N_CLASSES];
    logic signed [WIDTH-1:0] vec_d [N_CLASSES];
    logic                    eng_start;
    logic                    eng_done;
    logic [IDX_W-1:0]        eng_idx;

    rr_pick #(
        .NREQ(NREQ),
        .ID_W(ID_W)
    ) u_pick (
        .req      (req_valid),
        .last     (last_q),
        .grant    (grant),
        .grant_id (grant_id),
        .any      (any)
    );

    // The engine only ever sees the latched vector, so requesters may change
    // req_data freely once accepted.
    max_idx10 #(
        .WIDTH(WIDTH)
    ) u_engine (
        .clk    (clk),
        .reset  (reset),
        .start  (eng_start),
        .inputs (vec_q),
        .done   (eng_done),
        .idx    (eng_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    if (eng_done) state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready  = '0;
        accept     = 1'b0;
        eng_start  = (state_q == ISSUE);
        busy       = (state_q != IDLE);
        resp_valid = (state_q == RESP);
        if (state_q == IDLE && !reset) begin
            req_ready = grant;
            accept    = any;
        end
    end

    always_comb begin
        last_d     = last_q;
        id_d       = id_q;
        resp_idx_d = resp_idx_q;
        vec_d      = vec_q;
        if (accept) begin
            last_d = grant_id;
            id_d   = grant_id;
            vec_d  = req_data[grant_id];
        end
        if (state_q == WAIT && eng_done) begin
            resp_idx_d = eng_idx;
        end
    end

    // last resets to NREQ-1 so requester 0 is first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q     <= ID_W'(NREQ - 1);
            id_q       <= '0;
            resp_idx_q <= '0;
            vec_q      <= '{default: '0};
        end else begin
            last_q     <= last_d;
            id_q       <= id_d;
            resp_idx_q <= resp_idx_d;
            vec_q      <= vec_d;
        end
    end

    assign resp_idx = resp_idx_q;
    assign resp_id  = id_q;

endmodule

// File: tb/tb_max_idx_arbiter.sv
// Self-checking bench for max_idx_arbiter: directed table, multi-cycle corner
// sequences, and a randomized run against a transaction-level model.
module tb_max_idx_arbiter;
    import gusn_argmax_pkg::*;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int ID_W  = 2;

    typedef int vec_t [N_CLASSES];
    typedef struct {
        vec_t v;
        int   r;
        int   exp_idx;
    } vec_rec_t;

    logic                    clk = 1'b0;
    logic                    reset;
    logic [NREQ-1:0]         req_valid;
    logic signed [WIDTH-1:0] req_data [NREQ][N_CLASSES];
    logic [NREQ-1:0]         req_ready;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [IDX_W-1:0]        resp_idx;
    logic [ID_W-1:0]         resp_id;
    logic                    busy;

    int       n_pass  = 0;
    int       n_total = 0;
    int       acc_id[$];
    int       acc_cyc[$];
    int       rsp_id[$];
    int       rsp_idx[$];
    vec_rec_t tbl [6];
    vec_t     rv [NREQ];

    max_idx_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ),
        .ID_W (ID_W)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_idx   (resp_idx),
        .resp_id    (resp_id),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic chk(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input int r, input vec_t v);
        for (int i = 0; i < N_CLASSES; i++) req_data[r][i] = WIDTH'(v[i]);
    endtask

    function automatic int argmax(input vec_t v);
        int best = 0;
        for (int i = 1; i < N_CLASSES; i++) if (v[i] > v[best]) best = i;
        return best;
    endfunction

    function automatic int rr_model(input logic [NREQ-1:0] v, input int last);
        for (int k = 1; k <= NREQ; k++) if (v[(last + k) % NREQ]) return (last + k) % NREQ;
        return -1;
    endfunction

    // Random vector with a unique maximum at a random position.
    function automatic vec_t rand_vec();
        vec_t v;
        int   p;
        int   mx = -128;
        p = int'($urandom_range(0, N_CLASSES - 1));
        for (int i = 0; i < N_CLASSES; i++) begin
            v[i] = 0;
            if (i != p) begin
                v[i] = int'($urandom_range(0, 254)) - 128;
                if (v[i] > mx) mx = v[i];
            end
        end
        v[p] = mx + 1;
        return v;
    endfunction

    task automatic do_reset();
        req_valid  = '0;
        resp_ready = 1'b1;
        reset      = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic run_single(input int r, input vec_t v, input int exp_idx, input string tag);
        int n;
        load(r, v);
        req_valid    = '0;
        req_valid[r] = 1'b1;
        resp_ready   = 1'b1;
        #1;
        chk({tag, " req_ready"}, int'(req_ready), 1 << r);
        tick();
        req_valid = '0;
        n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk({tag, " latency"}, n, 6);
        chk({tag, " resp_idx"}, int'(resp_idx), exp_idx);
        chk({tag, " resp_id"}, int'(resp_id), r);
        tick();
        chk({tag, " pulse"}, int'(resp_valid), 0);
        chk({tag, " idle busy"}, int'(busy), 0);
    endtask

    task automatic observe(input int max_cyc, input int n_resp, input logic drop);
        int a;
        acc_id.delete();
        acc_cyc.delete();
        rsp_id.delete();
        rsp_idx.delete();
        for (int c = 0; c < max_cyc && rsp_id.size() < n_resp; c++) begin
            #1;
            a = -1;
            for (int r = 0; r < NREQ; r++) if (req_ready[r]) a = r;
            if (a >= 0) begin
                acc_id.push_back(a);
                acc_cyc.push_back(c);
            end
            if (resp_valid && resp_ready) begin
                rsp_id.push_back(int'(resp_id));
                rsp_idx.push_back(int'(resp_idx));
            end
            tick();
            if (drop && a >= 0) req_valid[a] = 1'b0;
        end
        chk("stream response count", rsp_id.size(), n_resp);
    endtask

    initial begin
        vec_t pv;
        int   n;
        int   seen;
        int   w;
        int   m_last;
        int   m_age;
        int   m_id;
        int   m_idx;
        bit   m_idle;

        tbl[0].v = '{3, -5, 7, 1, 0, 6, 2, -8, 5, 4};
        tbl[0].r = 0; tbl[0].exp_idx = 2;
        tbl[1].v = '{-128, -128, -128, -128, -128, -128, -128, -128, -128, -1};
        tbl[1].r = 0; tbl[1].exp_idx = 9;
        tbl[2].v = '{127, -128, -128, -128, -128, -128, -128, -128, -128, -1};
        tbl[2].r = 0; tbl[2].exp_idx = 0;
        tbl[3].v = '{10, 20, 30, 40, 50, 60, -60, -50, -40, -30};
        tbl[3].r = 1; tbl[3].exp_idx = 5;
        tbl[4].v = '{-1, -2, -3, -4, -5, -6, -7, -8, -9, -10};
        tbl[4].r = 3; tbl[4].exp_idx = 0;
        tbl[5].v = '{5, -3, 12, 44, -7, 0, 43, -44, 1, 2};
        tbl[5].r = 2; tbl[5].exp_idx = 3;

        // All four requesters valid from reset, each with a distinct planted max.
        reset      = 1'b1;
        resp_ready = 1'b1;
        req_valid  = '1;
        for (int r = 0; r < NREQ; r++) begin
            for (int i = 0; i < N_CLASSES; i++) pv[i] = i - 5;
            pv[(3 * r + 1) % N_CLASSES] = 100 + r;
            load(r, pv);
        end
        tick();
        tick();
        #1;
        chk("reset req_ready", int'(req_ready), 0);
        chk("reset resp_valid", int'(resp_valid), 0);
        chk("reset busy", int'(busy), 0);
        chk("reset resp_idx", int'(resp_idx), 0);
        chk("reset resp_id", int'(resp_id), 0);
        reset = 1'b0;
        observe(60, 4, 1'b1);
        chk("rr4 accept count", acc_id.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk("rr4 accept order", acc_id[k], k);
            chk("rr4 resp_id", rsp_id[k], k);
            chk("rr4 resp_idx", rsp_idx[k], (3 * k + 1) % N_CLASSES);
            if (k > 0) chk("rr4 accept spacing", acc_cyc[k] - acc_cyc[k-1], 7);
        end

        // Directed vectors, one transaction each.
        do_reset();
        for (int t = 0; t < 6; t++) run_single(tbl[t].r, tbl[t].v, tbl[t].exp_idx, "table");

        // Fairness: requester 1 served last, then 1 and 3 held valid.
        do_reset();
        run_single(1, tbl[3].v, tbl[3].exp_idx, "fair prime");
        for (int i = 0; i < N_CLASSES; i++) pv[i] = -i;
        pv[2] = 50;
        load(1, pv);
        pv[2] = -2;
        pv[8] = 60;
        load(3, pv);
        req_valid = 4'b1010;
        observe(60, 3, 1'b0);
        chk("fair 1st", rsp_id[0], 3);
        chk("fair 2nd", rsp_id[1], 1);
        chk("fair 3rd", rsp_id[2], 3);
        chk("fair idx 1st", rsp_idx[0], 8);
        chk("fair idx 2nd", rsp_idx[1], 2);

        // Backpressure: hold the response for 5 cycles.
        do_reset();
        load(0, tbl[0].v);
        req_valid  = 4'b0001;
        resp_ready = 1'b0;
        #1;
        chk("bp req_ready", int'(req_ready), 1);
        tick();
        req_valid = 4'b0010;
        n = 1;
        while (!resp_valid && n < 20) begin
            tick();
            n++;
        end
        chk("bp latency", n, 6);
        for (int k = 0; k < 5; k++) begin
            chk("bp resp_valid", int'(resp_valid), 1);
            chk("bp resp_idx", int'(resp_idx), 2);
            chk("bp resp_id", int'(resp_id), 0);
            chk("bp req_ready", int'(req_ready), 0);
            chk("bp busy", int'(busy), 1);
            tick();
        end
        resp_ready = 1'b1;
        #1;
        chk("bp release valid", int'(resp_valid), 1);
        tick();
        chk("bp done valid", int'(resp_valid), 0);
        chk("bp done busy", int'(busy), 0);
        chk("bp next grant", int'(req_ready), 2);

        // Reset during WAIT abandons the transaction.
        do_reset();
        load(0, tbl[1].v);
        req_valid = 4'b0001;
        tick();
        req_valid = '0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midreset busy", int'(busy), 0);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            if (resp_valid) seen++;
            tick();
        end
        chk("midreset no resp", seen, 0);
        run_single(2, tbl[5].v, tbl[5].exp_idx, "post reset");

        // Randomized traffic against a transaction-level model.
        do_reset();
        m_idle = 1'b1;
        m_last = NREQ - 1;
        m_age  = 0;
        m_id   = 0;
        m_idx  = 0;
        for (int c = 0; c < 500; c++) begin
            for (int r = 0; r < NREQ; r++) begin
                rv[r] = rand_vec();
                load(r, rv[r]);
            end
            req_valid  = ($urandom_range(0, 2) == 0) ? '0 : NREQ'($urandom());
            resp_ready = ($urandom_range(0, 3) != 0);
            #1;
            w = m_idle ? rr_model(req_valid, m_last) : -1;
            chk("rand req_ready", int'(req_ready), (w >= 0) ? (1 << w) : 0);
            chk("rand busy", int'(busy), m_idle ? 0 : 1);
            chk("rand resp_valid", int'(resp_valid), (!m_idle && m_age >= 6) ? 1 : 0);
            if (!m_idle && m_age >= 6) begin
                chk("rand resp_idx", int'(resp_idx), m_idx);
                chk("rand resp_id", int'(resp_id), m_id);
            end
            if (m_idle) begin
                if (w >= 0) begin
                    m_idle = 1'b0;
                    m_age  = 1;
                    m_id   = w;
                    m_idx  = argmax(rv[w]);
                    m_last = w;
                end
            end else if (m_age >= 6 && resp_ready) begin
                m_idle = 1'b1;
            end else begin
                m_age++;
            end
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
